id_ex_alu_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that drives the ALU's A, B and 3-bit control inputs.
- Captures decoded operands and control at the ID→EX boundary.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts a bubble. Latency from ID to ALU inputs is 1 clock.

---
 rtl/id_ex_alu_stage_if.sv | 57 +++++
 rtl/id_ex_alu_stage.sv | 112 +++++++++++
 tb/tb_id_ex_alu_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_alu_stage_if.sv
// ID/EX stage bundle: decode-side inputs, MEM/WB forwarding sources and the
// EX-side outputs that feed the ALU. Master drives ID/MEM/WB, slave is the stage.
interface id_ex_alu_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
);
   logic              stall;
   logic              flush;
   logic              id_valid;
   logic [DATA_W-1:0] id_rs_data;
   logic [DATA_W-1:0] id_rt_data;
   logic [DATA_W-1:0] id_imm;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic              id_uses_rt;
   logic              id_alu_src;
   logic              id_reg_dst;
   logic [2:0]        id_alu_ctrl;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   logic              mem_reg_write;
   logic [REG_AW-1:0] mem_rd;
   logic [DATA_W-1:0] mem_result;
   logic              wb_reg_write;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_result;
   logic              hazard_stall;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;
   logic [2:0]        ex_control;
   logic [DATA_W-1:0] ex_store_data;
   logic [REG_AW-1:0] ex_dest;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;

   modport master (
      output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
             id_rs, id_rt, id_rd, id_uses_rt, id_alu_src, id_reg_dst,
             id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
             mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
      input  hazard_stall, ex_valid, ex_a, ex_b, ex_control, ex_store_data,
             ex_dest, ex_reg_write, ex_mem_read, ex_mem_write
   );

   modport slave (
      input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
             id_rs, id_rt, id_rd, id_uses_rt, id_alu_src, id_reg_dst,
             id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
             mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
      output hazard_stall, ex_valid, ex_a, ex_b, ex_control, ex_store_data,
             ex_dest, ex_reg_write, ex_mem_read, ex_mem_write
   );
endinterface

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register with operand select for the ALU.
// Optional macro ID_EX_FWD_EN: enables MEM/WB forwarding and the load-use
// detector; when undefined, operands come straight from the stage register,
// hazard_stall is tied low and the mem_*/wb_* inputs are ignored.
module id_ex_alu_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input logic               clk,
   input logic               rst,
   id_ex_alu_stage_if.slave  bus
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] dest;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic              alu_src;
      logic [2:0]        ctrl;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
   } stage_t;

   stage_t            stage_q, stage_d;
   logic              hazard;
   logic [DATA_W-1:0] fwd_a;
   logic [DATA_W-1:0] fwd_rt;

   // Next stage contents: bubble beats stall, stall beats load.
   always_comb begin
      stage_d = stage_q;
      if (bus.flush || hazard) begin
         stage_d = '0;
      end else if (!bus.stall) begin
         stage_d.valid     = bus.id_valid;
         stage_d.rs        = bus.id_rs;
         stage_d.rt        = bus.id_rt;
         stage_d.dest      = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
         stage_d.rs_data   = bus.id_rs_data;
         stage_d.rt_data   = bus.id_rt_data;
         stage_d.imm       = bus.id_imm;
         stage_d.alu_src   = bus.id_alu_src;
         stage_d.ctrl      = bus.id_alu_ctrl;
         stage_d.reg_write = bus.id_reg_write & bus.id_valid;
         stage_d.mem_read  = bus.id_mem_read  & bus.id_valid;
         stage_d.mem_write = bus.id_mem_write & bus.id_valid;
      end
   end

   // Stage register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stage_q <= '0;
      else      stage_q <= stage_d;
   end

`ifdef ID_EX_FWD_EN
   // Forward rs: MEM result first, then WB data; index 0 is never forwarded.
   always_comb begin
      fwd_a = stage_q.rs_data;
      if (bus.mem_reg_write && bus.mem_rd == stage_q.rs && stage_q.rs != '0)
         fwd_a = bus.mem_result;
      else if (bus.wb_reg_write && bus.wb_rd == stage_q.rs && stage_q.rs != '0)
         fwd_a = bus.wb_result;
   end

   // Forward rt with the same priority.
   always_comb begin
      fwd_rt = stage_q.rt_data;
      if (bus.mem_reg_write && bus.mem_rd == stage_q.rt && stage_q.rt != '0)
         fwd_rt = bus.mem_result;
      else if (bus.wb_reg_write && bus.wb_rd == stage_q.rt && stage_q.rt != '0)
         fwd_rt = bus.wb_result;
   end

   // Load in EX whose destination the decoding instruction reads.
   always_comb begin
      hazard = bus.id_valid && stage_q.valid && stage_q.mem_read &&
               stage_q.dest != '0 &&
               (stage_q.dest == bus.id_rs ||
                (bus.id_uses_rt && stage_q.dest == bus.id_rt));
   end
`else
   logic unused_fwd;

   // No forwarding: registered operands pass straight through.
   always_comb begin
      fwd_a      = stage_q.rs_data;
      fwd_rt     = stage_q.rt_data;
      hazard     = 1'b0;
      unused_fwd = ^{bus.mem_reg_write, bus.mem_rd, bus.mem_result,
                     bus.wb_reg_write, bus.wb_rd, bus.wb_result,
                     bus.id_uses_rt, stage_q.rs, stage_q.rt};
   end
`endif

   assign bus.hazard_stall  = hazard;
   assign bus.ex_valid      = stage_q.valid;
   assign bus.ex_a          = fwd_a;
   assign bus.ex_store_data = fwd_rt;
   assign bus.ex_b          = stage_q.alu_src ? stage_q.imm : fwd_rt;
   assign bus.ex_control    = stage_q.ctrl;
   assign bus.ex_dest       = stage_q.dest;
   assign bus.ex_reg_write  = stage_q.reg_write;
   assign bus.ex_mem_read   = stage_q.mem_read;
   assign bus.ex_mem_write  = stage_q.mem_write;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Scoreboard bench for id_ex_alu_stage; expectations follow ID_EX_FWD_EN.
module tb_id_ex_alu_stage;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_ex_alu_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

   id_ex_alu_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // reference model of the stage register
   logic        m_valid, m_src, m_rw, m_mr, m_mw;
   logic [4:0]  m_rs, m_rt, m_dest;
   logic [2:0]  m_ctrl;
   logic [31:0] m_rsd, m_rtd, m_imm;

   typedef struct {
      logic [31:0] valid, a, b, st, ctrl, dest, rw, mr, mw, hz;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
`ifdef ID_EX_FWD_EN
      if (bus.mem_reg_write && bus.mem_rd == idx && idx != 0) return bus.mem_result;
      if (bus.wb_reg_write && bus.wb_rd == idx && idx != 0) return bus.wb_result;
`endif
      return v;
   endfunction

   function automatic logic model_hz();
`ifdef ID_EX_FWD_EN
      return bus.id_valid && m_valid && m_mr && m_dest != 0 &&
             (m_dest == bus.id_rs || (bus.id_uses_rt && m_dest == bus.id_rt));
`else
      return 1'b0;
`endif
   endfunction

   function automatic exp_t predict();
      exp_t e;
      e.valid = 32'(m_valid);
      e.a     = fwd(m_rs, m_rsd);
      e.st    = fwd(m_rt, m_rtd);
      e.b     = m_src ? m_imm : e.st;
      e.ctrl  = 32'(m_ctrl);
      e.dest  = 32'(m_dest);
      e.rw    = 32'(m_rw);
      e.mr    = 32'(m_mr);
      e.mw    = 32'(m_mw);
      e.hz    = 32'(model_hz());
      return e;
   endfunction

   task automatic model_clear();
      {m_valid, m_src, m_rw, m_mr, m_mw, m_rs, m_rt, m_dest, m_ctrl} = '0;
      {m_rsd, m_rtd, m_imm} = '0;
   endtask

   task automatic model_step();
      if (!rst || bus.flush || model_hz()) model_clear();
      else if (!bus.stall) begin
         m_valid = bus.id_valid;
         m_rs    = bus.id_rs;
         m_rt    = bus.id_rt;
         m_dest  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
         m_rsd   = bus.id_rs_data;
         m_rtd   = bus.id_rt_data;
         m_imm   = bus.id_imm;
         m_src   = bus.id_alu_src;
         m_ctrl  = bus.id_alu_ctrl;
         m_rw    = bus.id_reg_write & bus.id_valid;
         m_mr    = bus.id_mem_read & bus.id_valid;
         m_mw    = bus.id_mem_write & bus.id_valid;
      end
   endtask

   task automatic pop_compare();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check("ex_valid", 32'(bus.ex_valid), e.valid);
      check("ex_a", bus.ex_a, e.a);
      check("ex_b", bus.ex_b, e.b);
      check("ex_store_data", bus.ex_store_data, e.st);
      check("ex_control", 32'(bus.ex_control), e.ctrl);
      check("ex_dest", 32'(bus.ex_dest), e.dest);
      check("ex_reg_write", 32'(bus.ex_reg_write), e.rw);
      check("ex_mem_read", 32'(bus.ex_mem_read), e.mr);
      check("ex_mem_write", 32'(bus.ex_mem_write), e.mw);
      check("hazard_stall", 32'(bus.hazard_stall), e.hz);
   endtask

   // compare the combinational view of the current inputs
   task automatic settle();
      sb.push_back(predict());
      #1;
      pop_compare();
   endtask

   // one clock: check pre-edge state, predict post-edge outputs, compare after edge
   task automatic cycle();
      settle();
      model_step();
      sb.push_back(predict());
      @(posedge clk);
      #1;
      pop_compare();
   endtask

   task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic src, input logic dst,
                            input logic [2:0] ctrl, input logic rw, input logic mr, input logic mw);
      bus.id_valid = v;     bus.id_rs = rs;          bus.id_rt = rt;      bus.id_rd = rd;
      bus.id_rs_data = rsd; bus.id_rt_data = rtd;    bus.id_imm = imm;
      bus.id_alu_src = src; bus.id_reg_dst = dst;    bus.id_alu_ctrl = ctrl;
      bus.id_reg_write = rw; bus.id_mem_read = mr;   bus.id_mem_write = mw;
      bus.id_uses_rt = 1'b1;
   endtask

   task automatic fwd_off();
      bus.mem_reg_write = 1'b0; bus.mem_rd = '0; bus.mem_result = '0;
      bus.wb_reg_write  = 1'b0; bus.wb_rd  = '0; bus.wb_result  = '0;
   endtask

   initial begin
      model_clear();
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      set_instr(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      fwd_off();

      // reset held two cycles, then idle
      cycle();
      cycle();
      check("rst_valid", 32'(bus.ex_valid), 32'd0);
      check("rst_a", bus.ex_a, 32'd0);
      check("rst_hz", 32'(bus.hazard_stall), 32'd0);
      rst = 1'b1;
      cycle();
      check("idle_valid", 32'(bus.ex_valid), 32'd0);

      // ADD $3,$1,$2
      set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, '0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
      cycle();
      check("add_a", bus.ex_a, 32'd5);
      check("add_b", bus.ex_b, 32'd7);
      check("add_dest", 32'(bus.ex_dest), 32'd3);

      // MEM beats WB on rs=4, then WB alone, then rs=0 never forwarded
      set_instr(1'b1, 5'd4, 5'd2, 5'd6, 32'h55, 32'd1, '0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
      cycle();
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd4; bus.mem_result = 32'h11;
      bus.wb_reg_write  = 1'b1; bus.wb_rd  = 5'd4; bus.wb_result  = 32'h22;
      settle();
`ifdef ID_EX_FWD_EN
      check("fwd_mem_a", bus.ex_a, 32'h11);
`else
      check("fwd_mem_a", bus.ex_a, 32'h55);
`endif
      bus.mem_reg_write = 1'b0;
      settle();
      set_instr(1'b1, 5'd0, 5'd2, 5'd6, 32'h33, 32'd1, '0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
      cycle();
      check("fwd_zero_a", bus.ex_a, 32'h33);
      fwd_off();

      // load-use: lw $8 in EX, add reads $8
      set_instr(1'b1, 5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 32'd4, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
      cycle();
      set_instr(1'b1, 5'd8, 5'd2, 5'd10, 32'hDEAD, 32'd3, '0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
      cycle();
`ifdef ID_EX_FWD_EN
      check("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
      check("lu_bubble_rw", 32'(bus.ex_reg_write), 32'd0);
`endif
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd8; bus.mem_result = 32'h77;
      cycle();
      check("lu_capture_valid", 32'(bus.ex_valid), 32'd1);
      bus.mem_reg_write = 1'b0;
      bus.wb_reg_write = 1'b1; bus.wb_rd = 5'd8; bus.wb_result = 32'h77;
      settle();
      fwd_off();

      // immediate path with forwarded rt
      set_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'd2, 32'd1, 32'hFFFF_FFFC, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
      cycle();
      bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd5; bus.mem_result = 32'd9;
      settle();
      check("imm_b", bus.ex_b, 32'hFFFF_FFFC);
`ifdef ID_EX_FWD_EN
      check("imm_store", bus.ex_store_data, 32'd9);
`else
      check("imm_store", bus.ex_store_data, 32'd1);
`endif
      fwd_off();

      // flush and stall together -> bubble
      set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, '0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
      cycle();
      bus.stall = 1'b1; bus.flush = 1'b1;
      cycle();
      check("flush_valid", 32'(bus.ex_valid), 32'd0);
      bus.flush = 1'b0; bus.stall = 1'b0;
      cycle();
      // stall alone holds for three cycles while ID changes
      bus.stall = 1'b1;
      set_instr(1'b1, 5'd9, 5'd9, 5'd9, 32'h99, 32'h99, 32'h99, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1);
      for (int unsigned i = 0; i < 3; i++) cycle();
      check("stall_ctrl", 32'(bus.ex_control), 32'd1);
      bus.stall = 1'b0;

      // code 5 passes through, then reset during a load-use stall
      set_instr(1'b1, 5'd1, 5'd8, 5'd0, 32'd0, 32'd0, 32'd4, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
      cycle();
      check("ctrl5", 32'(bus.ex_control), 32'd5);
      set_instr(1'b1, 5'd2, 5'd8, 5'd10, 32'd1, 32'd1, '0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
      settle();
      #2;
      rst = 1'b0;
      model_clear();
      settle();
      check("rst_mid_hz", 32'(bus.hazard_stall), 32'd0);
      cycle();
      rst = 1'b1;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
